// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width default, ALU opcodes and the
// execute-stage FSM encoding. Used by alu_exec and its neighbouring stages.
package cpu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIVU = 4'd10;
  localparam logic [3:0] ALU_REMU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier (one multiplier bit per cycle) plus the
// optional restoring divider (one quotient bit per cycle) and the shared
// iteration counter. Optional divider: macro ALU_DIV_EN.
// i_load latches operands; i_step advances one iteration. The *_res/quot/rem
// outputs are the values after the current iteration, so the owner can
// register them on the final step edge.
module alu_iter_muldiv
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
`ifdef ALU_DIV_EN
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
`endif
  output logic [WIDTH-1:0] o_mul_res
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_mul_res  = w_acc_next;
  assign o_last     = (r_cnt == CW'(WIDTH - 1));

  // Multiplier state and iteration counter: load on issue, one bit per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (i_step) begin
      r_cnt    <= r_cnt + CW'(1);
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_acc    <= w_acc_next;
    end
  end

`ifdef ALU_DIV_EN
  // Restoring division: the dividend shifts out of r_quot MSB-first into the
  // partial remainder while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};
  assign w_ge    = ~w_diff[WIDTH];
  assign o_rem   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quot  = {r_quot[WIDTH-2:0], w_ge};

  // Divider state: load dividend/divisor on issue, one quotient bit per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_dvsr <= '0;
    end else if (i_load) begin
      r_quot <= i_a;
      r_rem  <= '0;
      r_dvsr <= i_b;
    end else if (i_step) begin
      r_quot <= o_quot;
      r_rem  <= o_rem;
    end
  end
`endif

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, iterative MUL and
// optional iterative DIVU/REMU behind a start/busy/done handshake.
// Optional divider: macro ALU_DIV_EN (ops 10/11 are illegal without it).
module alu_exec
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic             busy,
  output logic             done
);

  alu_state_t       r_state, w_state_next;
  logic [WIDTH-1:0] r_result, w_res_next, w_alu_res, w_mul_res;
  logic             r_zero, r_err, r_done;
  logic             w_err_next, w_alu_err, w_upd, w_load, w_step, w_last;
  logic [SHW-1:0]   w_shamt;

  assign w_shamt = B[SHW-1:0];
  assign result  = r_result;
  assign zero    = r_zero;
  assign err     = r_err;
  assign done    = r_done;
  assign busy    = (r_state != ST_IDLE);

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] w_quot, w_rem;
  logic [3:0]       r_op;

  // Remember which of DIVU/REMU is running so the right output is kept.
  always_ff @(posedge clk) begin
    if (rst)         r_op <= ALU_ADD;
    else if (w_load) r_op <= alu_op;
  end
`endif

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_a       (A),
    .i_b       (B),
    .o_last    (w_last),
`ifdef ALU_DIV_EN
    .o_quot    (w_quot),
    .o_rem     (w_rem),
`endif
    .o_mul_res (w_mul_res)
  );

  // Single-cycle op decode; anything not handled here reports illegal.
  always_comb begin
    w_alu_res = '0;
    w_alu_err = 1'b0;
    case (alu_op)
      ALU_ADD: w_alu_res = A + B;
      ALU_SUB: w_alu_res = A - B;
      ALU_AND: w_alu_res = A & B;
      ALU_OR:  w_alu_res = A | B;
      ALU_XOR: w_alu_res = A ^ B;
      ALU_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLL: w_alu_res = A << w_shamt;
      ALU_SRL: w_alu_res = A >> w_shamt;
      ALU_SRA: w_alu_res = $signed(A) >>> w_shamt;
      default: w_alu_err = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, iteration control and the value to register on completion.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_upd        = 1'b0;
    w_res_next   = r_result;
    w_err_next   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (alu_op == ALU_MUL) begin
            w_load       = 1'b1;
            w_state_next = ST_MUL;
`ifdef ALU_DIV_EN
          end else if (alu_op == ALU_DIVU || alu_op == ALU_REMU) begin
            if (B == '0) begin
              // Divide-by-zero resolves immediately without iterating.
              w_upd      = 1'b1;
              w_res_next = (alu_op == ALU_DIVU) ? '1 : A;
              w_err_next = 1'b1;
            end else begin
              w_load       = 1'b1;
              w_state_next = ST_DIV;
            end
`endif
          end else begin
            w_upd      = 1'b1;
            w_res_next = w_alu_res;
            w_err_next = w_alu_err;
          end
        end
      end
      ST_MUL: begin
        w_step = 1'b1;
        if (w_last) begin
          w_upd        = 1'b1;
          w_res_next   = w_mul_res;
          w_err_next   = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
`ifdef ALU_DIV_EN
      ST_DIV: begin
        w_step = 1'b1;
        if (w_last) begin
          w_upd        = 1'b1;
          w_res_next   = (r_op == ALU_REMU) ? w_rem : w_quot;
          w_err_next   = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output registers: updated together on completion, done pulses once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_upd;
      if (w_upd) begin
        r_result <= w_res_next;
        r_zero   <= (w_res_next == '0);
        r_err    <= w_err_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes expected result/zero/err and
// the cycle in which done must appear; a monitor pops on every done pulse.
// Divider vectors are compiled in when ALU_DIV_EN is defined.
module tb_alu_exec;
  import cpu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alu_op = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] result;
  logic         zero, err, busy, done;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  alu_exec #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .alu_op (alu_op),
    .A      (A),
    .B      (B),
    .result (result),
    .zero   (zero),
    .err    (err),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end else begin
      $display("chk %s: %h ok", name, act);
    end
  endtask

  // Drive one issue cycle and record what must come back and when.
  task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic e,
                       input int lat);
    exp_t x;
    start  = 1'b1;
    alu_op = op;
    A      = a;
    B      = b;
    x.res  = res;
    x.zero = (res == '0);
    x.err  = e;
    x.due  = cyc + lat;
    x.name = name;
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Count busy cycles; returns on the first cycle with busy low.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_done: got result=%h at cycle %0d, need no done", result, cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (result !== x.res || zero !== x.zero || err !== x.err || cyc != x.due) begin
          n_bad++;
          $display("FAIL %s: got res=%h zero=%b err=%b cyc=%0d, need res=%h zero=%b err=%b cyc=%0d",
                   x.name, result, zero, err, cyc, x.res, x.zero, x.err, x.due);
        end else begin
          $display("vec %s: res=%h zero=%b err=%b cyc=%0d ok", x.name, result, zero, err, cyc);
        end
      end
    end
  end

  initial begin
    int n;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_result", result, '0);
    chk("rst_zero", {31'b0, zero}, 1);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back single-cycle ops (start held high).
    issue("add_neg", ALU_ADD, 32'd5, 32'hFFFF_FFFD, 32'd2, 1'b0, 1);
    issue("sub_eq", ALU_SUB, 32'd7, 32'd7, 32'd0, 1'b0, 1);
    issue("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1);
    issue("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    issue("and", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
    issue("or", ALU_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1);
    issue("xor", ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1);
    issue("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
    issue("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
    issue("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    issue("slt_pos", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    issue("sll_31", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1);
    issue("sll_amt32", ALU_SLL, 32'h1234_5678, 32'd32, 32'h1234_5678, 1'b0, 1);
    issue("illegal12", 4'd12, 32'd3, 32'd4, 32'd0, 1'b1, 1);
    issue("illegal15", 4'd15, 32'd3, 32'd4, 32'd0, 1'b1, 1);
    issue("add_clr_err", ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    start = 1'b0;
    @(negedge clk);

    // Multiply timing and values.
    issue("mul_1234x5678", ALU_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 33);
    start = 1'b0;
    wait_busy(n);
    chk("mul_busy_cycles", n, 32);
    @(negedge clk);
    issue("mul_ones", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
    start = 1'b0;
    wait_busy(n);
    @(negedge clk);

    // Start while busy is ignored; start in the done cycle is accepted.
    issue("mul_3x5", ALU_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 33);
    start  = 1'b1;
    alu_op = ALU_ADD;
    A      = 32'd100;
    B      = 32'd200;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_busy(n);
    chk("mul_busy_rest", n, 29);
    chk("done_cycle_busy", {31'b0, busy}, 0);
    issue("add_in_done", ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-multiply: aborted, no done.
    issue("mul_aborted", ALU_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 33);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_result", result, '0);
    repeat (40) @(negedge clk);
    issue("add_after_abort", ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1);
    start = 1'b0;
    @(negedge clk);

`ifdef ALU_DIV_EN
    issue("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    start = 1'b0;
    wait_busy(n);
    chk("div_busy_cycles", n, 32);
    @(negedge clk);
    issue("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    start = 1'b0;
    wait_busy(n);
    @(negedge clk);
    issue("divu_by0", ALU_DIVU, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    issue("remu_by0", ALU_REMU, 32'd55, 32'd0, 32'd55, 1'b1, 1);
    start = 1'b0;
    @(negedge clk);
`else
    issue("op10_illegal", ALU_DIVU, 32'd100, 32'd7, 32'd0, 1'b1, 1);
    issue("op11_illegal", ALU_REMU, 32'd100, 32'd7, 32'd0, 1'b1, 1);
    start = 1'b0;
    @(negedge clk);
`endif

    // Drain outstanding expectations with a bounded wait.
    k = 0;
    while (sb.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no done, need res=%h by cycle %0d", x.name, x.res, x.due);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
